// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: legacy FSM
// encodings, the NOP returned to fetch while frozen, and a counter-width helper.
package imem_port_arbiter_pkg;

    localparam logic [1:0] S_FETCH    = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_HANDBACK = 2'd2;

    // MOV r0, r0 -- harmless filler while the PC is held
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    // Width needed to count 0 .. n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_arb_burst_counter.sv
// Loader burst counter: counts granted accesses within one ownership period
// and flags the last permitted access (count == MAX_LOAD_BURST-1).
module imem_arb_burst_counter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOAD_BURST = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = cnt_width(MAX_LOAD_BURST);

    logic [CNT_W-1:0] cnt;

    // Count granted accesses; held at zero outside loader ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(MAX_LOAD_BURST - 1));

endmodule

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter between the fetch stage and the
// program-loader/debug port. Loader bursts are bounded by MAX_LOAD_BURST and
// every loader period is followed by a HANDBACK cycle so fetch is not starved.
// Optional: define IMEM_ARB_PERF_CNT_EN to add the stall_cycles output.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_LOAD_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_freeze,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       in_load;
    logic       burst_tc;
    logic       rd_gnt;

    assign in_load = (state == S_LOAD);
    assign rd_gnt  = ld_gnt & ~ld_we;

    // Datapath steering is purely a function of the registered state, so an
    // asynchronous reset drops grant, freeze and any uncommitted write at once.
    assign ld_gnt       = in_load & ld_req;
    assign fetch_freeze = in_load;
    assign mem_addr     = in_load ? ld_addr : fetch_addr;
    assign mem_we       = ld_gnt & ld_we;
    assign mem_wdata    = ld_wdata;
    assign fetch_instr  = in_load ? DATA_W'(NOP_INSTR) : mem_rdata;

    imem_arb_burst_counter #(
        .MAX_LOAD_BURST (MAX_LOAD_BURST)
    ) u_burst_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (~in_load),
        .enable (ld_gnt),
        .tc     (burst_tc)
    );

    // Ownership sequencing: FETCH -> LOAD -> HANDBACK -> FETCH
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (ld_req) state_nxt = S_LOAD;
            S_LOAD:     if (!ld_req || burst_tc) state_nxt = S_HANDBACK;
            S_HANDBACK: state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Register loader read data one cycle after a granted read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_rdata  <= '0;
            ld_rvalid <= 1'b0;
        end else begin
            ld_rvalid <= rd_gnt;
            if (rd_gnt) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

`ifdef IMEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles the fetch stage is frozen by the loader
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (in_load && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill;
    logic [31:0] fetch_addr;
    logic        ld_req, ld_req1, ld_we;
    logic [31:0] ld_addr, ld_wdata;

    logic [31:0] fetch_instr, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        fetch_freeze, ld_gnt, ld_rvalid, mem_we;

    logic [31:0] fetch_instr1, ld_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        fetch_freeze1, ld_gnt1, ld_rvalid1, mem_we1;
`ifdef IMEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cycles, stall_cycles1;
`endif

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_q   [$];
    logic [31:0] mon_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOAD_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .fetch_freeze(fetch_freeze),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOAD_BURST(1)) dut1 (
        .clk(clk), .reset(reset),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr1), .fetch_freeze(fetch_freeze1),
        .ld_req(ld_req1), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt1), .ld_rdata(ld_rdata1), .ld_rvalid(ld_rvalid1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
`ifdef IMEM_ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles1)
`endif
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Instruction memory: combinational read, write on the clock edge
    assign mem_rdata  = mem[mem_addr[7:2]];
    assign mem_rdata1 = mem[mem_addr1[7:2]];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (mem_we && mem_addr[31:8] == 24'd0) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Scoreboard: every ld_rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (ld_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: ld_rvalid=1 with no read outstanding, ld_rdata=%h", ld_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ld_rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h expected %h", ld_rdata, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ld_req  = 1'b0;
        ld_req1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
        @(negedge clk);
        checks++; if (fetch_freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b expected 0", fetch_freeze); end
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", ld_gnt); end
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", ld_rvalid); end
        tick();
        reset = 1'b1; fill = 1'b0;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL rst_first_cycle_gnt: got %b expected 0", ld_gnt); end
        tick();
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL rst_first_grant: got %b expected 1", ld_gnt); end
        exp_q.push_back(ref_mem[4]);
        tick();
        ld_req = 1'b0;
        @(negedge clk);
        checks++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL rst_first_rvalid: got %b expected 1", ld_rvalid); end
        idle(3);
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            @(negedge clk);
            checks++; if (fetch_instr !== ref_mem[i]) begin errors++; $display("FAIL fetch_instr[%0d]: got %h expected %h", i, fetch_instr, ref_mem[i]); end
            checks++; if (fetch_freeze !== 1'b0) begin errors++; $display("FAIL fetch_freeze[%0d]: got %b expected 0", i, fetch_freeze); end
            checks++; if (mem_addr !== fetch_addr) begin errors++; $display("FAIL fetch_mem_addr[%0d]: got %h expected %h", i, mem_addr, fetch_addr); end
            tick();
        end
    endtask

    task automatic test_write_read();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF; fetch_addr = 32'h8;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL wr_wait_gnt: got %b expected 0", ld_gnt); end
        tick();
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b expected 1", ld_gnt); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL wr_mem_addr: got %h expected 00000010", mem_addr); end
        checks++; if (fetch_freeze !== 1'b1) begin errors++; $display("FAIL wr_freeze: got %b expected 1", fetch_freeze); end
        checks++; if (fetch_instr !== NOP) begin errors++; $display("FAIL wr_nop: got %h expected %h", fetch_instr, NOP); end
        tick();
        ref_mem[4] = 32'hDEADBEEF;
        ld_we = 1'b0;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", ld_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_after_write: got %b expected 0", ld_rvalid); end
        exp_q.push_back(ref_mem[4]);
        tick();
        ld_req = 1'b0;
        @(negedge clk);
        checks++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", ld_rvalid); end
        checks++; if (ld_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", ld_rdata); end
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL rd_release_gnt: got %b expected 0", ld_gnt); end
        checks++; if (fetch_freeze !== 1'b1) begin errors++; $display("FAIL rd_release_freeze: got %b expected 1", fetch_freeze); end
        tick();
        @(negedge clk);
        checks++; if (fetch_freeze !== 1'b0) begin errors++; $display("FAIL handback_freeze: got %b expected 0", fetch_freeze); end
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL handback_rvalid: got %b expected 0", ld_rvalid); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_written: got %h expected deadbeef", mem[4]); end
        idle(3);
    endtask

    task automatic test_burst_limit();
        int m_st = 0;
        int m_cnt = 0;
        int dut_grants = 0;
        logic exp_load;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            exp_load = (m_st == 1);
            checks++; if (ld_gnt !== exp_load) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", cyc, ld_gnt, exp_load); end
            checks++; if (fetch_freeze !== exp_load) begin errors++; $display("FAIL burst_freeze[%0d]: got %b expected %b", cyc, fetch_freeze, exp_load); end
            if (ld_gnt === 1'b1) dut_grants++;
            if (exp_load) exp_q.push_back(ref_mem[4]);
            case (m_st)
                0: begin m_st = 1; m_cnt = 0; end
                1: if (m_cnt == 7) m_st = 2; else m_cnt++;
                default: m_st = 0;
            endcase
            tick();
        end
        ld_req = 1'b0;
        checks++; if (dut_grants !== 16) begin errors++; $display("FAIL burst_total_grants: got %0d expected 16", dut_grants); end
        idle(3);
    endtask

    task automatic test_burst_one();
        int m_st = 0;
        logic exp_load;
        ld_req1 = 1'b1; ld_we = 1'b1; ld_addr = 32'h30; ld_wdata = 32'h1234_5678;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            exp_load = (m_st == 1);
            checks++; if (ld_gnt1 !== exp_load) begin errors++; $display("FAIL one_gnt[%0d]: got %b expected %b", cyc, ld_gnt1, exp_load); end
            checks++; if (fetch_freeze1 !== exp_load) begin errors++; $display("FAIL one_freeze[%0d]: got %b expected %b", cyc, fetch_freeze1, exp_load); end
            checks++; if (mem_we1 !== exp_load) begin errors++; $display("FAIL one_mem_we[%0d]: got %b expected %b", cyc, mem_we1, exp_load); end
            m_st = (m_st == 2) ? 0 : m_st + 1;
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_mid_load();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL mid_wait_gnt: got %b expected 0", ld_gnt); end
        tick();
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we: got %b expected 1", mem_we); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 0", ld_gnt); end
        checks++; if (fetch_freeze !== 1'b0) begin errors++; $display("FAIL mid_rst_freeze: got %b expected 0", fetch_freeze); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b expected 0", mem_we); end
        tick();
        ld_req = 1'b0;
        checks++; if (mem[8] !== ref_mem[8]) begin errors++; $display("FAIL mid_write_dropped: got %h expected %h", mem[8], ref_mem[8]); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata_cleared: got %h expected 00000000", ld_rdata); end
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0", ld_rvalid); end
        reset = 1'b1;
        fetch_addr = 32'h20;
        @(negedge clk);
        checks++; if (fetch_freeze !== 1'b0) begin errors++; $display("FAIL mid_post_freeze: got %b expected 0", fetch_freeze); end
        checks++; if (fetch_instr !== ref_mem[8]) begin errors++; $display("FAIL mid_post_fetch: got %h expected %h", fetch_instr, ref_mem[8]); end
        idle(3);
    endtask

`ifdef IMEM_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d expected 0", stall_cycles); end
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h30; ld_wdata = 32'h0BAD_F00D;
        repeat (5) tick();
        ld_req = 1'b0;
        repeat (2) tick();
        ref_mem[12] = 32'h0BAD_F00D;
        checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_count: got %0d expected 5", stall_cycles); end
        checks++; if (mem[12] !== ref_mem[12]) begin errors++; $display("FAIL perf_write: got %h expected %h", mem[12], ref_mem[12]); end
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt;
        ld_req = 1'b1;
        repeat (7) tick();
        ld_req = 1'b0;
        repeat (3) tick();
        checks++; if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_saturate: got %h expected ffffffff", stall_cycles); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; fill = 1'b1; fetch_addr = 32'h0;
        ld_req = 1'b0; ld_req1 = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);

        test_reset();
        test_fetch();
        test_write_read();
        test_burst_limit();
        test_burst_one();
        test_reset_mid_load();
`ifdef IMEM_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding reads expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
